gs_sdram_arbiter: RTL
=====================

// Module: gs_sdram_arbiter
// PURPOSE
//  Sequences the single GS SDRAM port among three requesters: ROM loader writes, GS Z80 memory
//  reads/writes, refresh. Sits between gs core / loader and the sdram controller, replacing the
//  combinational mux. Converts level strobes to one-cycle commands, buffers one loader write,
//  returns read data to the GS core with an explicit wait handshake.
// PARAMETERS
//  ADDR_W    25   SDRAM byte address width
//  RD_LAT    4    cycles from sdr_rd strobe to valid sdr_do (>=1)
//  RFSH_MAX  780  clk_sys cycles between forced refreshes (GS_ARB_AUTORFSH_EN only)
// PORTS
//  clk_sys    in   1      single clock; all logic on rising edge
//  reset_n    in   1      synchronous, active-low reset
//  loader_act in   1      loader owns SDRAM; GS requests and GS refresh ignored
//  loader_a   in   32     loader address; bit31 selects GS ROM space, [14:0] used
//  loader_d   in   8      loader write data
//  loader_wr  in   1      one-cycle loader write pulse
//  gs_ma      in   21     GS memory address
//  gs_mdo     in   8      GS write data
//  gs_mrd_n   in   1      GS read strobe, level, active-low
//  gs_mwe_n   in   1      GS write strobe, level, active-low
//  gs_mrfsh_n in   1      GS refresh strobe, level, active-low
//  gs_mdi     out  8      GS read data, held until next read completes
//  gs_wait_n  out  1      low while a GS access is pending or in flight
//  sdr_a      out  ADDR_W command address (GS: zero-extended gs_ma; loader: {0, loader_a[14:0]})
//  sdr_di     out  8      command write data
//  sdr_wr     out  1      one-cycle write command
//  sdr_rd     out  1      one-cycle read command
//  sdr_rfsh   out  1      one-cycle refresh command
//  sdr_do     in   8      controller read data
//  sdr_idle   in   1      controller ready for a command
//  load_ovf   out  1      sticky: loader pulse arrived while loader buffer full
// BEHAVIOUR
//  Reset: FSM=IDLE, pendings/buffer cleared, sdr_wr/rd/rfsh=0, sdr_a/sdr_di=0, gs_mdi=8'hFF,
//   gs_wait_n=1, load_ovf=0. Reset mid-access aborts it; no strobe issued in the following cycle.
//  Requests: falling edge (prev 1, now 0) of gs_mrd_n/gs_mwe_n/gs_mrfsh_n sets its pending flag
//   and latches gs_ma/gs_mdo; repeated edge while pending overwrites latch, single access.
//   Edges ignored while loader_act=1. gs_wait_n goes low the cycle after a GS rd/wr edge.
//  Loader: loader_act & loader_wr & loader_a[31] fills one-entry buffer; if full, pulse dropped,
//   buffer keeps old entry, load_ovf set. Pulses with loader_a[31]=0 ignored.
//  FSM IDLE->ISSUE->BUSY->IDLE. In IDLE with sdr_idle=1 pick by priority: loader buffer >
//   refresh > GS write > GS read; ISSUE drives exactly one strobe for one cycle with sdr_a/sdr_di
//   stable, clears the chosen pending. BUSY: read waits RD_LAT cycles, loads gs_mdi from sdr_do;
//   all kinds then wait for sdr_idle=1, no earlier than 2 cycles after the strobe.
//  Read latency: edge sampled cycle N -> sdr_rd at N+1 (if idle) -> gs_mdi valid and gs_wait_n=1
//   at N+1+RD_LAT. Write: gs_wait_n=1 the cycle after sdr_wr.
//  Simultaneous rd+wr edges: write first, then read. Loader buffer drains after loader_act falls.
// CONFIGURATION
//  GS_ARB_AUTORFSH_EN defined: counter reloads on every sdr_rfsh; on reaching RFSH_MAX an internal
//   refresh request is raised (honoured even while loader_act=1, priority just below loader).
//  Undefined: refresh only from gs_mrfsh_n edges, never during loader_act; no counter logic.
// STRUCTURE
//  Shared include gs_arb_pkg: FSM state encoding, request-kind codes, LOADER_SEL_BIT=31,
//   LOADER_ADDR_W=15. Sub-module gs_arb_req: falling-edge detector + pending flag + data latch,
//   instantiated for rd, wr, rfsh.
// TESTING
//  1 gs_mrd_n low with gs_ma=21'h01234, sdr_do=8'hA5 after RD_LAT -> one sdr_rd, sdr_a=25'h0001234,
//    gs_mdi=8'hA5 and gs_wait_n=1 at N+5.
//  2 loader_act=1, 2 loader_wr pulses (a=32'h8000_0010/11) 1 cycle apart, sdr_idle=0 -> first
//    written when idle, second dropped, load_ovf=1; loader_a=32'h0000_0010 -> no write.
//  3 rd+wr edges same cycle (gs_mdo=8'h3C) -> sdr_wr precedes sdr_rd, each single-cycle.
//  4 gs_mrfsh_n edge while loader_act=1 -> no sdr_rfsh (macro off); sdr_rfsh after RFSH_MAX (on).
//  5 reset_n low during BUSY read -> next cycle all strobes 0, gs_mdi=8'hFF, gs_wait_n=1.

Source files
------------

// File: rtl/gs_arb_pkg.sv
// ============================================================================
// Module : gs_arb_pkg
// Brief  : Shared FSM encoding, request-kind codes and loader constants for
//          the GS SDRAM arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package gs_arb_pkg;

  localparam int LOADER_SEL_BIT = 31;
  localparam int LOADER_ADDR_W  = 15;
  localparam int GS_ADDR_W      = 21;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2
  } arb_state_e;

  typedef enum logic [2:0] {
    K_NONE = 3'd0,
    K_LOAD = 3'd1,
    K_RFSH = 3'd2,
    K_WR   = 3'd3,
    K_RD   = 3'd4
  } req_kind_e;

endpackage

`default_nettype wire

// File: rtl/gs_arb_req.sv
// ============================================================================
// Module : gs_arb_req
// Brief  : Falling-edge detector with pending flag and address/data latch.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module gs_arb_req
  import gs_arb_pkg::*;
(
  input  logic                 clk_sys,
  input  logic                 reset_n,
  input  logic                 en_i,
  input  logic                 strobe_n_i,
  input  logic [GS_ADDR_W-1:0] addr_i,
  input  logic [7:0]           data_i,
  input  logic                 clr_i,
  output logic                 req_o,
  output logic                 pend_o,
  output logic [GS_ADDR_W-1:0] addr_o,
  output logic [7:0]           data_o
);

  logic                 prev_q;
  logic                 pend_q;
  logic [GS_ADDR_W-1:0] addr_q;
  logic [7:0]           data_q;
  logic                 w_edge;

  assign w_edge = en_i & prev_q & ~strobe_n_i;

  // A new edge wins over a same-cycle clear so it is never lost.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      prev_q <= 1'b1;
      pend_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      prev_q <= strobe_n_i;
      if (w_edge) begin
        pend_q <= 1'b1;
        addr_q <= addr_i;
        data_q <= data_i;
      end else if (clr_i) begin
        pend_q <= 1'b0;
      end
    end
  end

  assign req_o  = pend_q | w_edge;
  assign pend_o = pend_q;
  assign addr_o = w_edge ? addr_i : addr_q;
  assign data_o = w_edge ? data_i : data_q;

endmodule

`default_nettype wire

// File: rtl/gs_sdram_arbiter.sv
// ============================================================================
// Module : gs_sdram_arbiter
// Brief  : Sequences loader writes, GS Z80 reads/writes and refresh onto one
//          SDRAM port. Optional macro GS_ARB_AUTORFSH_EN adds forced refresh.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module gs_sdram_arbiter
  import gs_arb_pkg::*;
#(
  parameter int ADDR_W   = 25,
  parameter int RD_LAT   = 4,
  parameter int RFSH_MAX = 780
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              loader_act,
  input  logic [31:0]       loader_a,
  input  logic [7:0]        loader_d,
  input  logic              loader_wr,
  input  logic [20:0]       gs_ma,
  input  logic [7:0]        gs_mdo,
  input  logic              gs_mrd_n,
  input  logic              gs_mwe_n,
  input  logic              gs_mrfsh_n,
  output logic [7:0]        gs_mdi,
  output logic              gs_wait_n,
  output logic [ADDR_W-1:0] sdr_a,
  output logic [7:0]        sdr_di,
  output logic              sdr_wr,
  output logic              sdr_rd,
  output logic              sdr_rfsh,
  input  logic [7:0]        sdr_do,
  input  logic              sdr_idle,
  output logic              load_ovf
);

  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  arb_state_e                 state_q, state_d;
  req_kind_e                  kind_q, w_sel;
  logic [ADDR_W-1:0]          sdr_a_q;
  logic [7:0]                 sdr_di_q, gs_mdi_q, lb_d_q;
  logic [LOADER_ADDR_W-1:0]   lb_a_q;
  logic [LAT_W-1:0]           lat_q;
  logic                       rd_fly_q, gap_q, lb_v_q, load_ovf_q;
  logic                       w_start, w_gs_ok, w_fill, w_auto_rfsh, w_cfg_unused;
  logic                       w_rd_req, w_wr_req, w_rf_req, w_rd_pend, w_wr_pend, w_rf_pend;
  logic [GS_ADDR_W-1:0]       w_rd_addr, w_wr_addr, w_rf_addr;
  logic [7:0]                 w_rd_data, w_wr_data, w_rf_data;
  logic                       w_unused_bits;

  assign w_gs_ok = ~loader_act;
  assign w_fill  = loader_act & loader_wr & loader_a[LOADER_SEL_BIT];

  gs_arb_req u_req_rd (
    .clk_sys(clk_sys), .reset_n(reset_n), .en_i(w_gs_ok), .strobe_n_i(gs_mrd_n),
    .addr_i(gs_ma), .data_i(gs_mdo), .clr_i(sdr_rd),
    .req_o(w_rd_req), .pend_o(w_rd_pend), .addr_o(w_rd_addr), .data_o(w_rd_data)
  );

  gs_arb_req u_req_wr (
    .clk_sys(clk_sys), .reset_n(reset_n), .en_i(w_gs_ok), .strobe_n_i(gs_mwe_n),
    .addr_i(gs_ma), .data_i(gs_mdo), .clr_i(sdr_wr && (kind_q == K_WR)),
    .req_o(w_wr_req), .pend_o(w_wr_pend), .addr_o(w_wr_addr), .data_o(w_wr_data)
  );

  gs_arb_req u_req_rf (
    .clk_sys(clk_sys), .reset_n(reset_n), .en_i(w_gs_ok), .strobe_n_i(gs_mrfsh_n),
    .addr_i(gs_ma), .data_i(gs_mdo), .clr_i(sdr_rfsh),
    .req_o(w_rf_req), .pend_o(w_rf_pend), .addr_o(w_rf_addr), .data_o(w_rf_data)
  );

`ifdef GS_ARB_AUTORFSH_EN
  localparam int RC_W = $clog2(RFSH_MAX + 1);
  logic [RC_W-1:0] rfsh_cnt_q;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      rfsh_cnt_q <= '0;
    end else if (sdr_rfsh) begin
      rfsh_cnt_q <= '0;
    end else if (rfsh_cnt_q != RC_W'(RFSH_MAX)) begin
      rfsh_cnt_q <= rfsh_cnt_q + 1'b1;
    end
  end

  assign w_auto_rfsh  = (rfsh_cnt_q == RC_W'(RFSH_MAX));
  assign w_cfg_unused = 1'b0;
`else
  assign w_auto_rfsh  = 1'b0;
  assign w_cfg_unused = (RFSH_MAX == 0);
`endif

  // Loader buffer first, then refresh, GS write, GS read.
  always_comb begin
    w_sel = K_NONE;
    if (lb_v_q)                              w_sel = K_LOAD;
    else if ((w_rf_req & w_gs_ok) | w_auto_rfsh) w_sel = K_RFSH;
    else if (w_wr_req & w_gs_ok)             w_sel = K_WR;
    else if (w_rd_req & w_gs_ok)             w_sel = K_RD;
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    w_start  = 1'b0;
    sdr_wr   = 1'b0;
    sdr_rd   = 1'b0;
    sdr_rfsh = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sdr_idle && (w_sel != K_NONE)) begin
          state_d = ST_ISSUE;
          w_start = 1'b1;
        end
      end
      ST_ISSUE: begin
        state_d  = ST_BUSY;
        sdr_wr   = (kind_q == K_WR) || (kind_q == K_LOAD);
        sdr_rd   = (kind_q == K_RD);
        sdr_rfsh = (kind_q == K_RFSH);
      end
      ST_BUSY: begin
        if (!gap_q && !rd_fly_q && sdr_idle) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      kind_q     <= K_NONE;
      sdr_a_q    <= '0;
      sdr_di_q   <= '0;
      gs_mdi_q   <= 8'hFF;
      rd_fly_q   <= 1'b0;
      lat_q      <= '0;
      gap_q      <= 1'b0;
      lb_v_q     <= 1'b0;
      lb_a_q     <= '0;
      lb_d_q     <= '0;
      load_ovf_q <= 1'b0;
    end else begin
      // gap_q holds off the sdr_idle check until two cycles after the strobe.
      gap_q <= (state_q == ST_ISSUE);
      if (w_start) begin
        kind_q <= w_sel;
        case (w_sel)
          K_LOAD: begin
            sdr_a_q  <= ADDR_W'(lb_a_q);
            sdr_di_q <= lb_d_q;
          end
          K_WR: begin
            sdr_a_q  <= ADDR_W'(w_wr_addr);
            sdr_di_q <= w_wr_data;
          end
          K_RD: begin
            sdr_a_q  <= ADDR_W'(w_rd_addr);
            rd_fly_q <= 1'b1;
            lat_q    <= LAT_W'(RD_LAT - 1);
          end
          default: ;
        endcase
      end
      if (rd_fly_q) begin
        if (lat_q == '0) begin
          gs_mdi_q <= sdr_do;
          rd_fly_q <= 1'b0;
        end else begin
          lat_q <= lat_q - 1'b1;
        end
      end
      if (sdr_wr && (kind_q == K_LOAD)) lb_v_q <= 1'b0;
      if (w_fill) begin
        if (lb_v_q) begin
          load_ovf_q <= 1'b1;
        end else begin
          lb_v_q <= 1'b1;
          lb_a_q <= loader_a[LOADER_ADDR_W-1:0];
          lb_d_q <= loader_d;
        end
      end
    end
  end

  assign sdr_a     = sdr_a_q;
  assign sdr_di    = sdr_di_q;
  assign gs_mdi    = gs_mdi_q;
  assign load_ovf  = load_ovf_q;
  assign gs_wait_n = ~(w_rd_pend | w_wr_pend | rd_fly_q);

  assign w_unused_bits = ^{loader_a[LOADER_SEL_BIT-1:LOADER_ADDR_W], w_rd_data,
                           w_rf_addr, w_rf_data, w_rf_pend, w_cfg_unused};

endmodule

`default_nettype wire
